// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that funnels single read/write requests from NUM_REQ local
// requesters onto one APB slave, with a pready timeout and registered responses.
module apb_req_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [GW-1:0]   gnt;
    logic [GW-1:0]   last_gnt;
    logic [GW-1:0]   pick;
    logic            pick_valid;
    logic [7:0]      cnt;
    logic            timed_out;

    assign timed_out = (cnt >= 8'(TIMEOUT));

    // Walk from farthest to nearest so the requester closest after last_gnt wins.
    always_comb begin
        int idx;
        idx        = 0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_gnt) + k) % NUM_REQ;
            if (req[idx]) begin
                pick       = GW'(idx);
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        psel       = 1'b0;
        penable    = 1'b0;
        done       = '0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                psel       = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready || timed_out) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done[gnt]  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields are latched once at grant so requesters may change them freely afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= '0;
            last_gnt  <= GW'(NUM_REQ - 1);
            paddr     <= '0;
            pwdata    <= '0;
            pwrite    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt    <= pick;
                        paddr  <= req_addr[pick*ADDR_W +: ADDR_W];
                        pwdata <= req_wdata[pick*DATA_W +: DATA_W];
                        pwrite <= req_write[pick];
                        cnt    <= '0;
                    end
                end
                SETUP: begin
                    if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ACCESS: begin
                    if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                    if (pready) begin
                        rsp_rdata <= pwrite ? '0 : prdata;
                        rsp_err   <= pslverr;
                    end else if (timed_out) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end
                end
                DONE: begin
                    last_gnt <= gnt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_apb_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    done;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic [AW-1:0]   paddr;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic [DW-1:0]   prdata = '0;
    logic            pready = 1'b0;
    logic            pslverr = 1'b0;

    int checks = 0;
    int errors = 0;

    apb_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave: pready rises once the ACCESS phase has lasted more than cur_wait cycles.
    int          fixed_wait = 1;
    bit          fixed_data_en = 1'b1;
    logic [31:0] fixed_data = 32'h0;
    int          force_err = 0;
    int          acc = 0;
    int          cur_wait = 0;

    always @(negedge clk) begin
        if (psel && !penable) begin
            cur_wait = (fixed_wait >= 0) ? fixed_wait
                     : (($urandom % 10 == 0) ? 255 : int'($urandom_range(0, 3)));
        end
        if (psel && penable) acc++;
        else acc = 0;
        pready  = psel && penable && (acc > cur_wait);
        prdata  = fixed_data_en ? fixed_data : DW'($urandom);
        pslverr = pready && (force_err == 1 || (force_err == 2 && $urandom % 6 == 0));
    end

    // Transaction-level reference: m_age counts cycles since grant (0 = no transfer in flight).
    logic            s_rst;
    logic [N-1:0]    s_req;
    logic [N-1:0]    s_write;
    logic [N*AW-1:0] s_addr;
    logic [N*DW-1:0] s_wdata;
    logic            s_pready;
    logic            s_pslverr;
    logic [DW-1:0]   s_prdata;
    int              m_age = 0;
    int              m_gnt = 0;
    int              m_last = N - 1;
    bit              m_fin = 1'b0;
    logic [AW-1:0]   m_addr = '0;
    logic [DW-1:0]   m_wdata = '0;
    logic [DW-1:0]   m_rdata = '0;
    logic            m_write = 1'b0;
    logic            m_err = 1'b0;
    logic [N-1:0]    exp_done;

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        s_rst     = rst;
        s_req     = req;
        s_write   = req_write;
        s_addr    = req_addr;
        s_wdata   = req_wdata;
        s_pready  = pready;
        s_pslverr = pslverr;
        s_prdata  = prdata;
        #1;
        if (s_rst) begin
            m_age = 0; m_gnt = 0; m_last = N - 1; m_fin = 1'b0;
            m_addr = '0; m_wdata = '0; m_write = 1'b0; m_rdata = '0; m_err = 1'b0;
        end else if (m_fin) begin
            m_fin  = 1'b0;
            m_last = m_gnt;
        end else if (m_age == 0) begin
            if (s_req != '0) begin
                m_gnt   = rr_pick(s_req, m_last);
                m_addr  = s_addr[m_gnt*AW +: AW];
                m_wdata = s_wdata[m_gnt*DW +: DW];
                m_write = s_write[m_gnt];
                m_age   = 1;
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (s_pready) begin
            m_rdata = m_write ? '0 : s_prdata;
            m_err   = s_pslverr;
            m_fin   = 1'b1;
            m_age   = 0;
        end else if (m_age - 1 >= TO) begin
            m_rdata = '0;
            m_err   = 1'b1;
            m_fin   = 1'b1;
            m_age   = 0;
        end else begin
            m_age++;
        end
        exp_done = '0;
        if (m_fin) exp_done[m_gnt] = 1'b1;
        check_output("model_done", 64'(done), 64'(exp_done));
        check_output("model_psel", 64'(psel), 64'(m_age > 0));
        check_output("model_penable", 64'(penable), 64'(m_age >= 2));
        check_output("model_paddr", 64'(paddr), 64'(m_addr));
        check_output("model_pwrite", 64'(pwrite), 64'(m_write));
        check_output("model_pwdata", 64'(pwdata), 64'(m_wdata));
        check_output("model_rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
        check_output("model_rsp_err", 64'(rsp_err), 64'(m_err));
    end

    task automatic apply_stimulus(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i]         = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req[i]               = 1'b1;
    endtask

    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done == '0 && cyc < max_cyc);
        check_output("done_seen", 64'(done != '0), 64'(1));
        req = req & ~done;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int acc_cycles;
        int fair_exp[4];
        fair_exp = '{2, 3, 0, 1};

        // Reset values
        repeat (3) @(negedge clk);
        check_output("reset_done", 64'(done), 64'(0));
        check_output("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check_output("reset_rsp_err", 64'(rsp_err), 64'(0));
        check_output("reset_paddr", 64'(paddr), 64'(0));
        check_output("reset_ctrl", 64'({psel, penable, pwrite}), 64'(0));
        check_output("reset_pwdata", 64'(pwdata), 64'(0));
        rst = 1'b0;

        // Read from requester 0 against a registered-pready slave
        fixed_wait = 1; fixed_data = 32'hA5A5_0001; force_err = 0;
        @(negedge clk);
        apply_stimulus(0, 1'b0, 12'h008, 32'h0);
        @(negedge clk);
        check_output("rd_c1_psel", 64'({psel, penable}), 64'(2'b10));
        @(negedge clk);
        check_output("rd_c2_penable", 64'({psel, penable}), 64'(2'b11));
        check_output("rd_c2_paddr", 64'(paddr), 64'(12'h008));
        @(negedge clk);
        check_output("rd_c3_done", 64'(done), 64'(0));
        @(negedge clk);
        check_output("rd_c4_done", 64'(done), 64'(4'b0001));
        check_output("rd_rdata", 64'(rsp_rdata), 64'(32'hA5A5_0001));
        check_output("rd_err", 64'(rsp_err), 64'(0));
        req[0] = 1'b0;
        @(negedge clk);
        check_output("rd_done_pulse", 64'(done), 64'(0));

        // Write from requester 1
        apply_stimulus(1, 1'b1, 12'h018, 32'hDEAD_BEEF);
        @(negedge clk);
        check_output("wr_setup_pwrite", 64'(pwrite), 64'(1));
        check_output("wr_setup_pwdata", 64'(pwdata), 64'(32'hDEAD_BEEF));
        @(negedge clk);
        check_output("wr_access_ctrl", 64'({psel, penable, pwrite}), 64'(3'b111));
        check_output("wr_access_pwdata", 64'(pwdata), 64'(32'hDEAD_BEEF));
        wait_done(20, cyc);
        check_output("wr_done", 64'(done), 64'(4'b0010));
        check_output("wr_rdata", 64'(rsp_rdata), 64'(0));
        @(negedge clk);
        check_output("wr_done_pulse", 64'(done), 64'(0));

        // Fairness with every requester held
        fixed_wait = 0;
        for (int i = 0; i < N; i++) apply_stimulus(i, 1'b0, AW'(i * 4), 32'h0);
        for (int k = 0; k < 4; k++) begin
            wait_done(20, cyc);
            check_output("fair_grant", 64'(done), 64'(1) << fair_exp[k]);
            @(negedge clk);
            req = (k < 3) ? '1 : '0;
        end
        apply_stimulus(2, 1'b0, 12'h020, 32'h0);
        wait_done(20, cyc);
        check_output("rr_first_2", 64'(done), 64'(4'b0100));
        @(negedge clk);
        apply_stimulus(0, 1'b0, 12'h030, 32'h0);
        apply_stimulus(2, 1'b0, 12'h034, 32'h0);
        wait_done(20, cyc);
        check_output("rr_after_2_is_0", 64'(done), 64'(4'b0001));
        wait_done(20, cyc);
        check_output("rr_then_2", 64'(done), 64'(4'b0100));
        @(negedge clk);

        // Timeout: pready never rises
        fixed_wait = 255; fixed_data = 32'h1234_5678;
        @(negedge clk);
        apply_stimulus(3, 1'b0, 12'h0FC, 32'h0);
        acc_cycles = 0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (psel && penable) acc_cycles++;
        end while (done == '0 && cyc < 40);
        check_output("to_access_cycles", 64'(acc_cycles), 64'(16));
        check_output("to_done", 64'(done), 64'(4'b1000));
        check_output("to_err", 64'(rsp_err), 64'(1));
        check_output("to_rdata", 64'(rsp_rdata), 64'(0));
        req[3] = 1'b0;

        // Slave error together with pready
        fixed_wait = 1; force_err = 1;
        @(negedge clk);
        apply_stimulus(0, 1'b0, 12'h040, 32'h0);
        wait_done(20, cyc);
        check_output("slverr_done", 64'(done), 64'(4'b0001));
        check_output("slverr_err", 64'(rsp_err), 64'(1));
        check_output("slverr_rdata", 64'(rsp_rdata), 64'(32'h1234_5678));
        force_err = 0;
        @(negedge clk);

        // Reset in the middle of an ACCESS phase
        fixed_wait = 255;
        @(negedge clk);
        apply_stimulus(1, 1'b0, 12'h0A0, 32'h0);
        repeat (3) @(negedge clk);
        check_output("mid_rst_pre_penable", 64'(penable), 64'(1));
        rst = 1'b1;
        #1;
        check_output("mid_rst_psel", 64'(psel), 64'(0));
        check_output("mid_rst_penable", 64'(penable), 64'(0));
        apply_stimulus(0, 1'b0, 12'h0B0, 32'h0);
        fixed_wait = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output("mid_rst_no_done", 64'(done), 64'(0));
        end
        rst = 1'b0;
        wait_done(20, cyc);
        check_output("post_rst_first", 64'(done), 64'(4'b0001));
        check_output("post_rst_paddr0", 64'(paddr), 64'(12'h0B0));
        wait_done(20, cyc);
        check_output("post_rst_second", 64'(done), 64'(4'b0010));
        check_output("post_rst_paddr1", 64'(paddr), 64'(12'h0A0));
        @(negedge clk);

        // Address change after the grant is ignored
        apply_stimulus(0, 1'b0, 12'h010, 32'h0);
        @(negedge clk);
        req_addr[0 +: AW] = 12'h020;
        check_output("latch_setup_paddr", 64'(paddr), 64'(12'h010));
        @(negedge clk);
        check_output("latch_access_paddr", 64'(paddr), 64'(12'h010));
        wait_done(20, cyc);
        check_output("latch_done", 64'(done), 64'(4'b0001));
        check_output("latch_done_paddr", 64'(paddr), 64'(12'h010));
        @(negedge clk);

        // Randomized traffic, checked by the reference model every cycle
        fixed_wait = -1; fixed_data_en = 1'b0; force_err = 2;
        repeat (1500) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req[i] && done[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom % 4 == 0)
                        apply_stimulus(i, 1'($urandom), AW'($urandom), DW'($urandom));
                end else if ($urandom % 8 == 0) begin
                    req_addr[i*AW +: AW]  = AW'($urandom);
                    req_wdata[i*DW +: DW] = DW'($urandom);
                    req_write[i]          = 1'($urandom);
                end else if ($urandom % 60 == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        cyc = 0;
        while (req != '0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            req = req & ~done;
        end
        check_output("drain_complete", 64'(req), 64'(0));
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
